alu_arb_ctrl: RTL and testbench

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

---
 rtl/alu_arb_ctrl.sv | 136 +++++++++++++
 tb/tb_alu_arb_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arb_ctrl.sv
// rtl/alu_arb_ctrl.sv - two-requester arbiter and sequencer in front of a shared 4-bit ALU
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_arb_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic [3:0] r0_op,
    input  logic [3:0] r0_a,
    input  logic [3:0] r0_b,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic [3:0] r1_op,
    input  logic [3:0] r1_a,
    input  logic [3:0] r1_b,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_y,
    input  logic       alu_cf,
    input  logic       alu_bf,
    input  logic       alu_vf,
    input  logic       alu_zf,
    input  logic       alu_sf,
    input  logic       alu_pf,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_y,
    output logic [5:0] rsp_flags,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d, a_q, a_d, b_q, b_d;
    logic       id_q, id_d;
    logic       rsp_id_q, rsp_id_d;
    logic [3:0] rsp_y_q, rsp_y_d;
    logic [5:0] rsp_flags_q, rsp_flags_d;
    logic       grant1;
    logic       accept;

`ifdef ALU_ARB_RR_EN
    // prio_q names the port that wins the next contended cycle
    logic prio_q, prio_d;
    assign grant1 = r1_valid & (~r0_valid | prio_q);
`else
    assign grant1 = r1_valid & ~r0_valid;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        rsp_flags_d = rsp_flags_q;
        r0_ready    = 1'b0;
        r1_ready    = 1'b0;
        accept      = 1'b0;
`ifdef ALU_ARB_RR_EN
        prio_d      = prio_q;
`endif
        case (state_q)
            IDLE: begin
                r0_ready = rst_n & r0_valid & ~grant1;
                r1_ready = rst_n & grant1;
                accept   = r0_ready | r1_ready;
                if (accept) begin
                    op_d    = grant1 ? r1_op : r0_op;
                    a_d     = grant1 ? r1_a  : r0_a;
                    b_d     = grant1 ? r1_b  : r0_b;
                    id_d    = grant1;
                    state_d = EXEC;
`ifdef ALU_ARB_RR_EN
                    prio_d  = ~grant1;
`endif
                end
            end
            EXEC: begin
                rsp_y_d     = alu_y;
                rsp_flags_d = {alu_pf, alu_sf, alu_zf, alu_vf, alu_bf, alu_cf};
                rsp_id_d    = id_q;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 4'd0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            id_q        <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= 4'd0;
            rsp_flags_q <= 6'd0;
`ifdef ALU_ARB_RR_EN
            prio_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_flags_q <= rsp_flags_d;
`ifdef ALU_ARB_RR_EN
            prio_q      <= prio_d;
`endif
        end
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// tb/tb_alu_arb_ctrl.sv - randomized scoreboard bench for alu_arb_ctrl with a reference ALU attached
module tb_alu_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r0_valid = 1'b0, r1_valid = 1'b0;
    logic       r0_ready, r1_ready;
    logic [3:0] r0_op = 4'd0, r0_a = 4'd0, r0_b = 4'd0;
    logic [3:0] r1_op = 4'd0, r1_a = 4'd0, r1_b = 4'd0;
    logic [3:0] alu_op, alu_a, alu_b, alu_y;
    logic       alu_cf, alu_bf, alu_vf, alu_zf, alu_sf, alu_pf;
    logic       rsp_valid, rsp_id, busy;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_y;
    logic [5:0] rsp_flags;

    always #5 clk = ~clk;

    alu_arb_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .alu_cf(alu_cf), .alu_bf(alu_bf), .alu_vf(alu_vf),
        .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_pf(alu_pf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .busy(busy)
    );

    // Reference ALU: returns {pf,sf,zf,vf,bf,cf,y}
    function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia, ib, sa, sb, r, s;
        logic [3:0] y;
        logic cf, bf, vf, zf, sf, pf;
        ia = int'(a); ib = int'(b);
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        cf = 1'b0; bf = 1'b0; vf = 1'b0;
        case (op)
            4'd0: begin r = ia + ib; s = sa + sb; cf = (r > 15); vf = (s > 7) || (s < -8); end
            4'd1: begin r = ia - ib; s = sa - sb; bf = (ia < ib); vf = (s > 7) || (s < -8); end
            4'd2: r = ia & ib;
            4'd3: r = ia | ib;
            4'd4: r = ia ^ ib;
            default: r = ia;
        endcase
        y  = r[3:0];
        zf = (y == 4'd0);
        sf = (int'(y) >= 8);
        pf = ($countones(y) % 2) == 0;
        return {pf, sf, zf, vf, bf, cf, y};
    endfunction

    always_comb {alu_pf, alu_sf, alu_zf, alu_vf, alu_bf, alu_cf, alu_y} = alu_fn(alu_op, alu_a, alu_b);

    typedef struct {
        logic       id;
        logic [3:0] y;
        logic [5:0] fl;
        int         vcyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   shown = 1'b0;

    bit         m_pend = 1'b0;
    int         m_resp_cyc = 0;
    logic [3:0] m_op = 4'd0, m_a = 4'd0, m_b = 4'd0;
    bit         m_last = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic cycle(input bit v0, input bit v1,
                         input logic [3:0] o0, input logic [3:0] a0, input logic [3:0] b0,
                         input logic [3:0] o1, input logic [3:0] a1, input logic [3:0] b1,
                         input bit rr, input bit rn);
        bit e0, e1, win;
        logic [9:0] res;
        exp_t e;
        @(posedge clk);
        #1;
        r0_valid = v0; r0_op = o0; r0_a = a0; r0_b = b0;
        r1_valid = v1; r1_op = o1; r1_a = a1; r1_b = b1;
        rsp_ready = rr; rst_n = rn;
        #1;
        e0 = 1'b0; e1 = 1'b0; win = 1'b0;
        if (rn && !m_pend && (v0 || v1)) begin
`ifdef ALU_ARB_RR_EN
            win = (v0 && v1) ? ~m_last : v1;
`else
            win = v1 && !v0;
`endif
            e0 = !win;
            e1 = win;
        end
        chk("r0_ready", r0_ready, e0);
        chk("r1_ready", r1_ready, e1);
        chk("busy", busy, m_pend);
        chk("rsp_valid", rsp_valid, m_pend && (cyc >= m_resp_cyc));
        chk("alu_opab", {alu_op, alu_a, alu_b}, {m_op, m_a, m_b});
        if (!rn) begin
            sbq.delete();
            m_pend = 1'b0;
            m_op = 4'd0; m_a = 4'd0; m_b = 4'd0;
            m_last = 1'b1;
        end else if (e0 || e1) begin
            m_op = win ? o1 : o0;
            m_a  = win ? a1 : a0;
            m_b  = win ? b1 : b0;
            res = alu_fn(m_op, m_a, m_b);
            e.id = win; e.y = res[3:0]; e.fl = res[9:4]; e.vcyc = cyc + 2;
            sbq.push_back(e);
            m_pend = 1'b1;
            m_resp_cyc = cyc + 2;
            m_last = win;
        end else if (m_pend && cyc >= m_resp_cyc && rr) begin
            m_pend = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            shown = 1'b0;
        end else if (rsp_valid && cyc > 0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                if (!shown) begin
                    chk("rsp_latency", cyc, sbq[0].vcyc);
                    shown = 1'b1;
                end
                chk("rsp_id", rsp_id, sbq[0].id);
                chk("rsp_y", rsp_y, sbq[0].y);
                chk("rsp_flags", rsp_flags, sbq[0].fl);
                if (rsp_ready) begin
                    void'(sbq.pop_front());
                    shown = 1'b0;
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        cycle(1, 1, 0, 1, 2, 3, 4, 5, 1, 0);
        cycle(1, 1, 0, 1, 2, 3, 4, 5, 1, 0);
        chk("reset_rsp_y", rsp_y, 0);
        chk("reset_rsp_flags", rsp_flags, 0);
        chk("reset_rsp_id", rsp_id, 0);

        cycle(1, 0, 4'd0, 4'd7, 4'd1, 0, 0, 0, 1, 1);
        repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        cycle(0, 1, 0, 0, 0, 4'd1, 4'd0, 4'd1, 1, 1);
        repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 14; i++)
            cycle(1, 1, 4'($urandom_range(0, 5)), 4'($urandom), 4'($urandom),
                  4'($urandom_range(0, 5)), 4'($urandom), 4'($urandom), 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        cycle(1, 1, 4'd0, 4'd9, 4'd9, 4'd1, 4'd3, 4'd4, 0, 1);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (5) cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        cycle(1, 0, 4'd2, 4'd15, 4'd6, 0, 0, 0, 1, 1);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 3000; i++)
            cycle(($urandom % 3) != 0, ($urandom % 3) != 0,
                  4'($urandom_range(0, 6)), 4'($urandom), 4'($urandom),
                  4'($urandom_range(0, 6)), 4'($urandom), 4'($urandom),
                  ($urandom % 3) != 0, ($urandom % 150) != 0);

        repeat (6) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
